eth_tx_framer: RTL and testbench

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

---
 rtl/eth_tx_framer_if.sv | 28 ++
 rtl/eth_tx_framer.sv | 192 +++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_framer_if.sv
// Payload source / PHY transmit bundle for eth_tx_framer.
// master = frame source (and PHY observer), slave = the framer itself.
interface eth_tx_framer_if #(
   parameter int unsigned pMII_WIDTH = 2
);
   logic [47:0]           Dest_Addr;
   logic [47:0]           Src_Addr;
   logic [15:0]           Len_Type;
   logic [7:0]            Eth_Byte;
   logic                  Eth_Byte_Valid;
   logic                  Eth_Byte_Last;
   logic                  Eth_Byte_Rdy;
   logic [pMII_WIDTH-1:0] Tx_Data;
   logic                  Tx_En;
   logic                  Tx_Busy;
   logic                  Tx_Done;
   logic                  Tx_Err;

   modport master (
      output Dest_Addr, Src_Addr, Len_Type, Eth_Byte, Eth_Byte_Valid, Eth_Byte_Last,
      input  Eth_Byte_Rdy, Tx_Data, Tx_En, Tx_Busy, Tx_Done, Tx_Err
   );

   modport slave (
      input  Dest_Addr, Src_Addr, Len_Type, Eth_Byte, Eth_Byte_Valid, Eth_Byte_Last,
      output Eth_Byte_Rdy, Tx_Data, Tx_En, Tx_Busy, Tx_Done, Tx_Err
   );
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet MAC transmit framer: preamble/SFD, header, payload, zero pad, FCS, IFG onto a MII-style
// bus. Define ETH_TX_FRAMER_FCS_EN to append the CRC-32 FCS; without it PAD/DATA go straight to IFG.
module eth_tx_framer #(
   parameter int unsigned pMII_WIDTH   = 2,
   parameter int unsigned pMIN_PAYLOAD = 46,
   parameter int unsigned pMAX_PAYLOAD = 1500,
   parameter int unsigned pIFG_BYTES   = 12
) (
   input logic            Clk,
   input logic            Rst_n,
   eth_tx_framer_if.slave bus
);
   localparam int unsigned K  = 8 / pMII_WIDTH;
   localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(K - 1);
   localparam logic [10:0] MIN_CNT  = 11'(pMIN_PAYLOAD);
   localparam logic [10:0] MAX_CNT  = 11'(pMAX_PAYLOAD);
   localparam logic [10:0] IFG_LAST = 11'(pIFG_BYTES - 1);

   localparam logic [3:0] sIdle     = 4'd0;
   localparam logic [3:0] sPreamble = 4'd1;
   localparam logic [3:0] sSfd      = 4'd2;
   localparam logic [3:0] sDest     = 4'd3;
   localparam logic [3:0] sSrc      = 4'd4;
   localparam logic [3:0] sLen      = 4'd5;
   localparam logic [3:0] sData     = 4'd6;
   localparam logic [3:0] sPad      = 4'd7;
   localparam logic [3:0] sIfg      = 4'd9;
`ifdef ETH_TX_FRAMER_FCS_EN
   localparam logic [3:0] sFcs      = 4'd8;
   localparam logic [3:0] sAfterPay = sFcs;
`else
   localparam logic [3:0] sAfterPay = sIfg;
`endif

   logic [3:0]    stateQ, stateD;
   logic [CW-1:0] cycQ, cycD;
   logic [10:0]   byteQ, byteD;
   logic [10:0]   payQ, payD;
   logic [47:0]   destQ, destD, srcQ, srcD;
   logic [15:0]   lenQ, lenD;
   logic [7:0]    dataQ, dataD;
   logic          lastQ, lastD;
   logic          doneQ, doneD, errQ, errD;
   logic          byteEnd, rdy, txEn, startFrame;
   logic [7:0]    curByte, txShift;

`ifdef ETH_TX_FRAMER_FCS_EN
   logic [31:0]   crcQ, crcD;

   // Reflected CRC-32, one byte, LSB first.
   function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction
`endif

   assign byteEnd = (cycQ == CYC_LAST);
   assign rdy     = byteEnd && ((stateQ == sLen && byteQ == 11'd1) ||
                                (stateQ == sData && !lastQ && payQ < MAX_CNT));
   assign txEn    = (stateQ != sIdle) && (stateQ != sIfg);
   // The last IFG cycle doubles as the IDLE decision so back-to-back frames keep the exact gap.
   assign startFrame = bus.Eth_Byte_Valid &&
                       (stateQ == sIdle || (stateQ == sIfg && byteEnd && byteQ == IFG_LAST));

   always_comb begin
      curByte = 8'h00;
      case (stateQ)
         sPreamble: curByte = 8'h55;
         sSfd:      curByte = 8'hD5;
         sDest:     curByte = 8'(destQ >> {3'd5 - byteQ[2:0], 3'b000});
         sSrc:      curByte = 8'(srcQ >> {3'd5 - byteQ[2:0], 3'b000});
         sLen:      curByte = 8'(lenQ >> {~byteQ[0], 3'b000});
         sData:     curByte = dataQ;
`ifdef ETH_TX_FRAMER_FCS_EN
         sFcs:      curByte = 8'((~crcQ) >> {byteQ[1:0], 3'b000});
`endif
         default:   curByte = 8'h00;
      endcase
   end

   assign txShift          = curByte >> (cycQ * pMII_WIDTH);
   assign bus.Tx_Data      = txEn ? txShift[pMII_WIDTH-1:0] : '0;
   assign bus.Tx_En        = txEn;
   assign bus.Tx_Busy      = (stateQ != sIdle);
   assign bus.Eth_Byte_Rdy = rdy;
   assign bus.Tx_Done      = doneQ;
   assign bus.Tx_Err       = errQ;

   always_comb begin
      stateD = stateQ;
      cycD   = (stateQ == sIdle || byteEnd) ? '0 : cycQ + 1'b1;
      byteD  = (byteEnd && stateQ != sIdle) ? byteQ + 11'd1 : byteQ;
      payD   = payQ;
      destD  = destQ;
      srcD   = srcQ;
      lenD   = lenQ;
      dataD  = dataQ;
      lastD  = lastQ;
      doneD  = 1'b0;
      errD   = 1'b0;
`ifdef ETH_TX_FRAMER_FCS_EN
      crcD   = crcQ;
      if (byteEnd && stateQ >= sDest && stateQ <= sPad) crcD = crcByte(crcQ, curByte);
`endif
      case (stateQ)
         sPreamble: if (byteEnd && byteQ == 11'd6) begin stateD = sSfd; byteD = '0; end
         sSfd:      if (byteEnd) begin stateD = sDest; byteD = '0; end
         sDest:     if (byteEnd && byteQ == 11'd5) begin stateD = sSrc; byteD = '0; end
         sSrc:      if (byteEnd && byteQ == 11'd5) begin stateD = sLen; byteD = '0; end
         sLen, sData: begin
            if (byteEnd && (stateQ == sData || byteQ == 11'd1)) begin
               byteD = '0;
               if (stateQ == sData && lastQ) begin
                  stateD = (payQ < MIN_CNT) ? sPad : sAfterPay;
                  doneD  = (payQ >= MIN_CNT) && (sAfterPay == sIfg);
               end else if (rdy && bus.Eth_Byte_Valid) begin
                  stateD = sData;
                  dataD  = bus.Eth_Byte;
                  lastD  = bus.Eth_Byte_Last;
                  payD   = (payQ == '1) ? payQ : payQ + 11'd1;
               end else begin
                  // Underrun or oversize: finish the current byte, then abort.
                  stateD = sIfg;
                  errD   = 1'b1;
               end
            end
         end
         sPad: begin
            if (byteEnd && ({1'b0, payQ} + {1'b0, byteQ} + 12'd1) >= {1'b0, MIN_CNT}) begin
               stateD = sAfterPay;
               byteD  = '0;
               doneD  = (sAfterPay == sIfg);
            end
         end
`ifdef ETH_TX_FRAMER_FCS_EN
         sFcs: if (byteEnd && byteQ == 11'd3) begin stateD = sIfg; byteD = '0; doneD = 1'b1; end
`endif
         sIfg:      if (byteEnd && byteQ == IFG_LAST) begin stateD = sIdle; byteD = '0; end
         default:   stateD = sIdle;
      endcase
      if (startFrame) begin
         stateD = sPreamble;
         cycD   = '0;
         byteD  = '0;
         payD   = '0;
         lastD  = 1'b0;
         destD  = bus.Dest_Addr;
         srcD   = bus.Src_Addr;
         lenD   = bus.Len_Type;
`ifdef ETH_TX_FRAMER_FCS_EN
         crcD   = 32'hFFFF_FFFF;
`endif
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stateQ <= sIdle;
         cycQ   <= '0;
         byteQ  <= '0;
         payQ   <= '0;
         destQ  <= '0;
         srcQ   <= '0;
         lenQ   <= '0;
         dataQ  <= '0;
         lastQ  <= 1'b0;
         doneQ  <= 1'b0;
         errQ   <= 1'b0;
`ifdef ETH_TX_FRAMER_FCS_EN
         crcQ   <= '0;
`endif
      end else begin
         stateQ <= stateD;
         cycQ   <= cycD;
         byteQ  <= byteD;
         payQ   <= payD;
         destQ  <= destD;
         srcQ   <= srcD;
         lenQ   <= lenD;
         dataQ  <= dataD;
         lastQ  <= lastD;
         doneQ  <= doneD;
         errQ   <= errD;
`ifdef ETH_TX_FRAMER_FCS_EN
         crcQ   <= crcD;
`endif
      end
   end
endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer at pMII_WIDTH=2: frame contents, lengths, pad, FCS residue,
// underrun, oversize, mid-frame reset and inter-frame gap.
module tb_eth_tx_framer;
   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   always #5 Clk = ~Clk;

   eth_tx_framer_if #(.pMII_WIDTH(2)) bus ();
   eth_tx_framer #(.pMII_WIDTH(2)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

   localparam logic [47:0] DEST = 48'h0011_2233_4455;
   localparam logic [47:0] SRC  = 48'h6677_8899_AABB;
   localparam logic [15:0] LEN  = 16'h0800;
`ifdef ETH_TX_FRAMER_FCS_EN
   localparam int EN10 = 288, EN47 = 292, EN100 = 504;
`else
   localparam int EN10 = 272, EN47 = 276, EN100 = 488;
`endif

   int nChk = 0, nBad = 0;
   bit [7:0] rxQ[$];
   int frameStart[$], enLens[$], gaps[$];
   int doneCnt = 0, errCnt = 0, hsCnt = 0, errWithEn = 0, zeroViol = 0;

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChk++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

`ifdef ETH_TX_FRAMER_FCS_EN
   function automatic logic [31:0] crcUpd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
         else r = r >> 1;
      end
      return r;
   endfunction
`endif

   function automatic logic [7:0] payB(input int f, input int i);
      return 8'((f * 29 + i * 7 + 3) % 256);
   endfunction

   // Wire-side monitor: reassemble bytes LSB first, measure Tx_En runs and gaps.
   initial begin
      int lowRun, enRun, bitPos;
      logic [7:0] rxByte;
      bit enPrev;
      lowRun = 0; enRun = 0; bitPos = 0; rxByte = '0; enPrev = 1'b0;
      forever begin
         @(negedge Clk);
         if (bus.Tx_En) begin
            if (!enPrev) begin
               frameStart.push_back(rxQ.size());
               gaps.push_back(lowRun);
               lowRun = 0; enRun = 0; bitPos = 0; rxByte = '0;
            end
            enRun++;
            rxByte[bitPos +: 2] = bus.Tx_Data;
            bitPos += 2;
            if (bitPos == 8) begin
               rxQ.push_back(rxByte);
               bitPos = 0;
               rxByte = '0;
            end
         end else begin
            if (enPrev) enLens.push_back(enRun);
            lowRun++;
            if (bus.Tx_Data != 2'b00) zeroViol++;
         end
         enPrev = bus.Tx_En;
         if (bus.Tx_Done) doneCnt++;
         if (bus.Tx_Err) errCnt++;
         if (bus.Tx_Err && bus.Tx_En) errWithEn++;
         if (bus.Eth_Byte_Rdy && bus.Eth_Byte_Valid) hsCnt++;
      end
   end

   task automatic sendFrame(input int f, input int n, input int dropAt, input bit hold,
                            input bit noLast);
      int idx, guard;
      bit hs;
      idx = 0; guard = 0;
      bus.Dest_Addr = DEST; bus.Src_Addr = SRC; bus.Len_Type = LEN;
      bus.Eth_Byte = payB(f, 0);
      bus.Eth_Byte_Last = !noLast && (n == 1);
      bus.Eth_Byte_Valid = 1'b1;
      while (idx < n && idx != dropAt && guard < 20000) begin
         @(negedge Clk); #1;
         hs = bus.Eth_Byte_Rdy && bus.Eth_Byte_Valid;
         @(posedge Clk); #1;
         guard++;
         if (hs) begin
            idx++;
            if (idx < n) begin
               bus.Eth_Byte = payB(f, idx);
               bus.Eth_Byte_Last = !noLast && (idx == n - 1);
            end
         end
      end
      if (guard >= 20000) checkEq($sformatf("f%0d send timeout", f), guard, 0);
      if (!hold || idx != n) begin
         bus.Eth_Byte_Valid = 1'b0;
         bus.Eth_Byte_Last = 1'b0;
      end
   endtask

   task automatic waitEvents(input int target, input string tag);
      int g;
      g = 0;
      while (doneCnt + errCnt < target && g < 20000) begin
         @(negedge Clk); #1;
         g++;
      end
      if (g >= 20000) checkEq(tag, doneCnt + errCnt, target);
      repeat (2) @(negedge Clk);
      #1;
   endtask

   task automatic checkFrame(input int f, input int n, input int expEn);
      bit [7:0] e[$];
      logic [47:0] d, s;
      logic [15:0] l;
      int pl, st, cnt, mism;
      d = DEST; s = SRC; l = LEN;
      pl = (n < 46) ? 46 : n;
      for (int i = 0; i < 7; i++) e.push_back(8'h55);
      e.push_back(8'hD5);
      for (int k = 5; k >= 0; k--) e.push_back(d[8*k +: 8]);
      for (int k = 5; k >= 0; k--) e.push_back(s[8*k +: 8]);
      e.push_back(l[15:8]);
      e.push_back(l[7:0]);
      for (int i = 0; i < pl; i++) e.push_back((i < n) ? payB(f, i) : 8'h00);
`ifdef ETH_TX_FRAMER_FCS_EN
      begin
         logic [31:0] c;
         c = 32'hFFFF_FFFF;
         for (int i = 8; i < e.size(); i++) c = crcUpd(c, e[i]);
         c = ~c;
         for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
      end
`endif
      if (f >= frameStart.size() || f >= enLens.size()) begin
         checkEq($sformatf("f%0d seen", f), 0, 1);
         return;
      end
      st = frameStart[f];
      cnt = ((f + 1 < frameStart.size()) ? frameStart[f + 1] : rxQ.size()) - st;
      checkEq($sformatf("f%0d byte count", f), cnt, e.size());
      checkEq($sformatf("f%0d tx_en cycles", f), enLens[f], expEn);
      mism = 0;
      for (int i = 0; i < e.size(); i++)
         if (st + i >= rxQ.size() || rxQ[st + i] != e[i]) mism++;
      checkEq($sformatf("f%0d bad bytes", f), mism, 0);
`ifdef ETH_TX_FRAMER_FCS_EN
      begin
         logic [31:0] r;
         r = 32'hFFFF_FFFF;
         for (int i = 8; i < cnt; i++) r = crcUpd(r, rxQ[st + i]);
         checkEq($sformatf("f%0d crc residue", f), r, 32'hDEBB_20E3);
      end
`endif
   endtask

   initial begin
      int d0, e0, h0;
      int g;
      bus.Dest_Addr = '0; bus.Src_Addr = '0; bus.Len_Type = '0;
      bus.Eth_Byte = '0; bus.Eth_Byte_Valid = 1'b0; bus.Eth_Byte_Last = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      checkEq("reset ctl", {bus.Tx_En, bus.Tx_Busy, bus.Eth_Byte_Rdy, bus.Tx_Done, bus.Tx_Err}, 0);
      checkEq("reset data", bus.Tx_Data, 0);
      @(negedge Clk) Rst_n = 1'b1;
      repeat (3) @(negedge Clk);

      // Short payload: padded to minimum.
      d0 = doneCnt; e0 = errCnt;
      sendFrame(0, 10, -1, 1'b0, 1'b0);
      waitEvents(d0 + e0 + 1, "f0 end timeout");
      checkEq("f0 done", doneCnt - d0, 1);
      checkEq("f0 err", errCnt - e0, 0);
      checkFrame(0, 10, EN10);

      // Long payload, no pad.
      d0 = doneCnt; e0 = errCnt; h0 = hsCnt;
      sendFrame(1, 100, -1, 1'b0, 1'b0);
      waitEvents(d0 + e0 + 1, "f1 end timeout");
      checkEq("f1 done", doneCnt - d0, 1);
      checkEq("f1 handshakes", hsCnt - h0, 100);
      checkFrame(1, 100, EN100);

      // Underrun at the 5th Rdy.
      d0 = doneCnt; e0 = errCnt;
      sendFrame(2, 10, 4, 1'b0, 1'b0);
      waitEvents(d0 + e0 + 1, "f2 end timeout");
      checkEq("f2 err", errCnt - e0, 1);
      checkEq("f2 done", doneCnt - d0, 0);
      checkEq("f2 err with tx_en", errWithEn, 0);
      if (enLens.size() > 2) checkEq("f2 tx_en cycles", enLens[2], 104);
      else checkEq("f2 seen", 0, 1);

      // Back-to-back, Valid held through the gap.
      d0 = doneCnt; e0 = errCnt;
      sendFrame(3, 46, -1, 1'b1, 1'b0);
      sendFrame(4, 47, -1, 1'b0, 1'b0);
      waitEvents(d0 + e0 + 2, "f3/f4 end timeout");
      checkEq("f3/f4 done", doneCnt - d0, 2);
      checkFrame(3, 46, EN10);
      checkFrame(4, 47, EN47);
      if (gaps.size() > 4) begin
         checkEq("gap after underrun >= 48", gaps[3] >= 48, 1);
         checkEq("back-to-back gap", gaps[4], 48);
      end else checkEq("f4 seen", 0, 1);

      // Reset in the middle of SRC_ADDR.
      d0 = doneCnt; e0 = errCnt;
      bus.Eth_Byte = payB(5, 0); bus.Eth_Byte_Last = 1'b0; bus.Eth_Byte_Valid = 1'b1;
      g = 0;
      while (!bus.Tx_En && g < 2000) begin
         @(negedge Clk);
         g++;
      end
      repeat (64) @(posedge Clk);
      #2 Rst_n = 1'b0;
      bus.Eth_Byte_Valid = 1'b0;
      #1;
      checkEq("mid reset ctl", {bus.Tx_En, bus.Tx_Busy, bus.Eth_Byte_Rdy}, 0);
      checkEq("mid reset data", bus.Tx_Data, 0);
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      checkEq("reset no done/err", (doneCnt - d0) + (errCnt - e0), 0);
      d0 = doneCnt; e0 = errCnt;
      sendFrame(6, 10, -1, 1'b0, 1'b0);
      waitEvents(d0 + e0 + 1, "f6 end timeout");
      checkEq("f6 done", doneCnt - d0, 1);
      checkFrame(6, 10, EN10);
      if (gaps.size() > 6) checkEq("no gap after reset", gaps[6] < 48, 1);

      // Oversize: 1500 bytes without Last.
      d0 = doneCnt; e0 = errCnt; h0 = hsCnt;
      sendFrame(7, 1500, -1, 1'b0, 1'b1);
      waitEvents(d0 + e0 + 1, "f7 end timeout");
      checkEq("f7 err", errCnt - e0, 1);
      checkEq("f7 done", doneCnt - d0, 0);
      checkEq("f7 handshakes", hsCnt - h0, 1500);
      if (enLens.size() > 7) checkEq("f7 tx_en cycles", enLens[7], 6088);
      else checkEq("f7 seen", 0, 1);

      checkEq("tx_data zero while idle", zeroViol, 0);
      $display("test done: total=%0d bad=%0d", nChk, nBad);
      $finish;
   end
endmodule
